// File: rtl/wheel_speed.sv
// Wheel-sensor period measurement and km/h conversion: the period between accepted
// rising edges feeds a 24-step restoring divider; standstill is reported as 0 km/h.
module wheel_speed #(
  parameter int TICK_CYCLES   = 1000,
  parameter int CIRC_MM       = 2100,
  parameter int MIN_PERIOD_MS = 20,
  parameter int TIMEOUT_MS    = 4000,
  parameter int KMH_MAX       = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wheel,
  output logic [6:0] kmh,
  output logic       valid
);

  localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_CYCLES - 1);
  localparam logic [15:0]   MIN_P     = 16'(MIN_PERIOD_MS);
  localparam logic [15:0]   TO_P      = 16'(TIMEOUT_MS);
  localparam logic [15:0]   TO_M1     = 16'(TIMEOUT_MS - 1);
  localparam logic [23:0]   NUM       = 24'(CIRC_MM * 36);
  localparam logic [4:0]    DIV_STEPS = 5'd24;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    DIVIDE     = 2'd2
  } state_t;

  state_t        state_q;
  logic          sync1_q, sync2_q, sync3_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   period_q, period_d;
  logic [15:0]   per_q, pend_q;
  logic          pend_flag_q;
  logic [4:0]    cnt_q;
  logic [23:0]   num_q, rem_q, quo_q, den;
  logic [24:0]   trial;
  logic          rise, tick, accept, timeout, div_done, start_div;

  function automatic logic [6:0] sat_kmh(input logic [23:0] q);
    if (q > 24'(KMH_MAX)) return 7'(KMH_MAX);
    return q[6:0];
  endfunction

  assign rise      = sync2_q & ~sync3_q;
  assign tick      = (presc_q == PRE_MAX);
  assign accept    = rise && (state_q == WAIT_FIRST || period_q >= MIN_P);
  assign timeout   = tick && (period_q == TO_M1) && (state_q != WAIT_FIRST);
  assign div_done  = (state_q == DIVIDE) && (cnt_q == DIV_STEPS);
  // A finished division restarts at once if an edge is pending or arrives right now.
  assign start_div = (state_q == MEASURE && accept) ||
                     (div_done && !timeout && (accept || pend_flag_q));
  assign den       = {8'd0, per_q} * 24'd10;
  assign trial     = {rem_q, num_q[23]};

  always_comb begin
    presc_d  = presc_q;
    period_d = period_q;
    if (accept) begin
      presc_d  = '0;
      period_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (period_q < TO_P) period_d = period_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Input synchronizer and millisecond timebase
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      presc_q  <= '0;
      period_q <= '0;
    end else begin
      sync1_q  <= wheel;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      presc_q  <= presc_d;
      period_q <= period_d;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_FIRST;
      kmh         <= '0;
      valid       <= 1'b0;
      pend_flag_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        WAIT_FIRST: if (accept) state_q <= MEASURE;
        MEASURE: begin
          if (accept) begin
            state_q <= DIVIDE;
            cnt_q   <= '0;
          end else if (timeout) begin
            kmh     <= '0;
            valid   <= 1'b1;
            state_q <= WAIT_FIRST;
          end
        end
        DIVIDE: begin
          if (timeout) begin
            kmh         <= '0;
            valid       <= 1'b1;
            pend_flag_q <= 1'b0;
            state_q     <= WAIT_FIRST;
          end else if (div_done) begin
            kmh         <= sat_kmh(quo_q);
            valid       <= 1'b1;
            pend_flag_q <= 1'b0;
            cnt_q       <= '0;
            if (!(accept || pend_flag_q)) state_q <= MEASURE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
            if (accept) pend_flag_q <= 1'b1;
          end
        end
        default: state_q <= WAIT_FIRST;
      endcase
    end
  end

  // Divider datapath: one quotient bit per cycle, numerator shifted in MSB first
  always_ff @(posedge clk) begin
    if (state_q == DIVIDE && !div_done && accept) pend_q <= period_q;
    if (start_div) begin
      per_q <= accept ? period_q : pend_q;
      num_q <= NUM;
      rem_q <= '0;
      quo_q <= '0;
    end else if (state_q == DIVIDE && !div_done) begin
      num_q <= {num_q[22:0], 1'b0};
      if (trial >= {1'b0, den}) begin
        rem_q <= 24'(trial - {1'b0, den});
        quo_q <= {quo_q[22:0], 1'b1};
      end else begin
        rem_q <= trial[23:0];
        quo_q <= {quo_q[22:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_wheel_speed.sv
// Directed bench for wheel_speed: dut_a uses a short tick/timeout for cruise, bounce,
// stop and reset cases; dut_b (TICK_CYCLES=1, MIN_PERIOD_MS=1) covers the pending edge.
module tb_wheel_speed;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wheel_a = 1'b0, wheel_b = 1'b0;
  logic [6:0] kmh_a, kmh_b;
  logic       valid_a, valid_b;

  wheel_speed #(.TICK_CYCLES(4), .CIRC_MM(2100), .MIN_PERIOD_MS(20),
                .TIMEOUT_MS(400), .KMH_MAX(99)) dut_a (
    .clk(clk), .reset(reset), .wheel(wheel_a), .kmh(kmh_a), .valid(valid_a));

  wheel_speed #(.TICK_CYCLES(1), .CIRC_MM(50), .MIN_PERIOD_MS(1),
                .TIMEOUT_MS(4000), .KMH_MAX(99)) dut_b (
    .clk(clk), .reset(reset), .wheel(wheel_b), .kmh(kmh_b), .valid(valid_b));

  always #5 clk = ~clk;

  int cyc = 0, hi_a = 0, hi_b = 0;
  int nva = 0, tva = -1, kva = -1;
  int tvb[$];
  int kvb[$];
  int npass = 0, ntotal = 0;
  int la = 0;

  // An edge `gap` cycles after the previous one: the tick coinciding with the
  // accepted rise is not counted, so whole ticks measured = (gap-1)/tc.
  function automatic int exp_kmh(input int gap, input int tc, input int circ);
    int per, q;
    per = (gap - 1) / tc;
    q   = (circ * 36) / (per * 10);
    return (q > 99) ? 99 : q;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hi_a > 0) begin hi_a--; if (hi_a == 0) wheel_a = 1'b0; end
      if (hi_b > 0) begin hi_b--; if (hi_b == 0) wheel_b = 1'b0; end
      if (valid_a === 1'b1) begin nva++; tva = cyc; kva = int'(kmh_a); end
      if (valid_b === 1'b1) begin tvb.push_back(cyc); kvb.push_back(int'(kmh_b)); end
    end
  endtask

  // n = index of the clock edge that first samples the wheel high
  task automatic press_a(output int n);
    wheel_a = 1'b1; hi_a = 3; n = cyc + 1;
  endtask

  task automatic press_b(output int n);
    wheel_b = 1'b1; hi_b = 3; n = cyc + 1;
  endtask

  task automatic speed_edge(input string tag, input int hold);
    int n, v0, s;
    v0 = nva;
    press_a(n);
    s  = n - la;
    la = n;
    step(hold);
    check({tag, "_count"}, nva - v0, 1);
    check({tag, "_time"}, tva, n + 27);
    check({tag, "_kmh"}, kva, exp_kmh(s, 4, 2100));
  endtask

  initial begin
    int n, v0, n0, n1, n2, t0, t1, k0, k1;

    step(3);
    reset = 1'b0;
    step(1);
    check("reset_kmh", int'(kmh_a), 0);
    check("reset_valid", int'(valid_a), 0);
    check("reset_state", int'(dut_a.state_q), 0);
    check("reset_kmh_b", int'(kmh_b), 0);

    v0 = nva;
    press_a(n); la = n;
    step(800);
    check("first_count", nva - v0, 0);
    check("first_kmh", int'(kmh_a), 0);
    check("first_state", int'(dut_a.state_q), 1);

    speed_edge("cruise200", 304);
    speed_edge("fast76", 800);
    speed_edge("cruise200b", 200);
    speed_edge("sat50", 400);
    speed_edge("mid100", 800);

    v0 = nva;
    press_a(n);
    step(20);
    press_a(n1);
    step(780);
    check("bounce_count", nva - v0, 1);
    check("bounce_time", tva, n + 27);
    check("bounce_kmh", kva, exp_kmh(n - la, 4, 2100));
    la = n;
    speed_edge("after_bounce", 800);

    v0 = nva;
    step(900);
    check("stop_count", nva - v0, 1);
    check("stop_time", tva, la + 2 + 400 * 4);
    check("stop_kmh", kva, 0);
    check("stop_state", int'(dut_a.state_q), 0);

    v0 = nva;
    press_a(n); la = n;
    step(800);
    check("restart_count", nva - v0, 0);
    check("restart_state", int'(dut_a.state_q), 1);
    speed_edge("restart_speed", 800);

    v0 = nva;
    press_a(n);
    step(11);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(100);
    check("rstdiv_count", nva - v0, 0);
    check("rstdiv_kmh", int'(kmh_a), 0);
    check("rstdiv_state", int'(dut_a.state_q), 0);

    v0 = nva;
    press_a(n); la = n;
    step(800);
    check("postrst_count", nva - v0, 0);
    check("postrst_state", int'(dut_a.state_q), 1);
    speed_edge("postrst_speed", 800);

    press_b(n0);
    step(20);
    press_b(n1);
    step(10);
    press_b(n2);
    step(80);
    t0 = (tvb.size() > 0) ? tvb[0] : -1;
    k0 = (kvb.size() > 0) ? kvb[0] : -1;
    t1 = (tvb.size() > 1) ? tvb[1] : -1;
    k1 = (kvb.size() > 1) ? kvb[1] : -1;
    check("pend_count", tvb.size(), 2);
    check("pend_t0", t0, n1 + 27);
    check("pend_k0", k0, exp_kmh(n1 - n0, 1, 50));
    check("pend_t1", t1, n1 + 52);
    check("pend_k1", k1, exp_kmh(n2 - n1, 1, 50));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/wheel_speed.md
# wheel_speed

Converts the raw wheel-sensor pulse into the instantaneous speed `kmh` (0–99 km/h) consumed by the max-speed tracker, the average computer and the display.
- Measures the period between accepted rising edges in milliseconds.
- Divides a fixed circumference constant by that period with a sequential divider.
- Publishes the saturated result with a one-cycle `valid` strobe.
- Reports 0 km/h when the wheel stops.

## Interface
- `TICK_CYCLES`, 1000: clock cycles per 1 ms tick (1 MHz clk).
- `CIRC_MM`, 2100: wheel circumference in mm.
- `MIN_PERIOD_MS`, 20: edges closer than this to the last accepted edge are bounce and ignored.
- `TIMEOUT_MS`, 4000: no accepted edge for this long means standstill.
- `KMH_MAX`, 99: saturation value of `kmh`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wheel`  in  1  raw reed/hall sensor level, asynchronous to `clk`.
- `kmh`  out  7  current speed in km/h, 0..KMH_MAX.
- `valid`  out  1  one-cycle pulse when `kmh` is (re)written.

## Operation
- **Input path:** `wheel` passes through a 2-FF synchronizer, then a registered rising-edge detector, giving `rise`, one cycle wide.
- **Millisecond timebase:**
  - A prescaler counts 0..TICK_CYCLES-1 and emits `tick` on wrap.
  - `period_ms` (16 bit) increments on `tick` and saturates at TIMEOUT_MS.
  - Both are cleared on every accepted edge.
- **FSM states:** WAIT_FIRST, MEASURE, DIVIDE.
  - **WAIT_FIRST:** any `rise` is accepted; it clears the timebase and moves to MEASURE. No speed update.
  - **MEASURE:**
    - `rise` with `period_ms` < MIN_PERIOD_MS is ignored; the timebase is not cleared.
    - `rise` with `period_ms` ≥ MIN_PERIOD_MS is accepted: `period_ms` is latched into `per_q`, the timebase is cleared, and the FSM goes to DIVIDE.
    - `period_ms` reaching TIMEOUT_MS writes `kmh`=0, pulses `valid` and returns to WAIT_FIRST.
  - **DIVIDE:**
    - A restoring divider computes floor(CIRC_MM*36 / (per_q*10)) in exactly 24 cycles.
    - Numerator and divisor are 24 bit; CIRC_MM*36 must be < 2^24.
    - On completion `kmh` = min(quotient, KMH_MAX), `valid` pulses, and the FSM returns to MEASURE.
    - The timebase keeps running during DIVIDE.
- **Edge during DIVIDE:** the current division is not aborted.
  - An accepted edge (same MIN_PERIOD_MS test) latches its period into `pend_q`, sets `pend_flag` and clears the timebase.
  - On completion with `pend_flag` set, the FSM re-enters DIVIDE with `per_q`=`pend_q` on the next cycle and clears the flag.
  - A second pending edge overwrites `pend_q`.
- **Timeout during DIVIDE** cannot occur with legal parameters (TIMEOUT_MS ≫ divide time); if it does, timeout has priority and forces `kmh`=0 and WAIT_FIRST.
- Quotient bits above 6 are only used for the saturation compare; `kmh` never exceeds KMH_MAX.

## Timing
- **Reset:** applies on the `clk` edge where `reset`=1 and overrides every other event in that cycle.
  - Reset values: `kmh`=0, `valid`=0, FSM=WAIT_FIRST, prescaler=0, `period_ms`=0, `pend_flag`=0, synchronizer=0.
  - Reset mid-DIVIDE discards the division; no `valid`.
- **Latency:** `wheel` first sampled high at edge n gives `rise` at n+2; the edge is accepted and `per_q` loaded at n+2; DIVIDE runs n+3..n+26; `kmh`/`valid` update at edge n+27.
- `valid` is high for exactly one cycle per update; `kmh` holds between updates.
- **Period resolution:** 1 ms, truncating. The measured period of an edge is the count of whole ticks since the previous accepted edge.
- **Timeout:** `valid` with `kmh`=0 fires on the edge where `period_ms` becomes TIMEOUT_MS, i.e. TIMEOUT_MS*TICK_CYCLES cycles after the last accepted edge.
- **Simultaneous `tick` and accepted `rise`:** `rise` wins. The period latched is the pre-increment value and the timebase clears.

## Test plan
- **Reset then first edge:** reset, one `wheel` pulse → no `valid`, `kmh`=0, FSM in MEASURE.
- **Steady cruise:** edges every 200 ms (defaults) → each edge after the first gives `valid` 27 cycles after sampling with `kmh`=37 (75600/2000=37.8). Edges every 76 ms → `kmh`=99.
- **Saturation and bounce:**
  - Edges every 50 ms → `kmh`=99 (151 clamped).
  - A glitch edge 5 ms after an accepted edge is ignored; the next real edge at 200 ms still gives `kmh`=37.
- **Stop:** after the last edge, no edges for 4000 ms → `valid` with `kmh`=0 at exactly 4000*TICK_CYCLES cycles, FSM=WAIT_FIRST. The next single edge gives no update.
- **Pending edge:** with TICK_CYCLES=1 and MIN_PERIOD_MS=1, edges spaced 20 and then 10 cycles apart so the second lands mid-DIVIDE → first result published, second division starts the cycle after, two `valid` pulses 25 cycles apart with the correct quotients.
- **Reset mid-DIVIDE:** assert `reset` 10 cycles into a division → no `valid`, `kmh`=0. The next edge is treated as the first edge.
